// File: rtl/wave_pkg.sv
// wave_pkg: shared state encoding, bank geometry and sample conversion for the waveform RAM path
package wave_pkg;
    localparam int SAMPLE_W = 16;
    localparam int BANK_AW = 8;
    localparam int BANK_DEPTH = 2 ** BANK_AW;

    typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

    function automatic logic [7:0] to_offset(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]};
    endfunction
endpackage

// File: rtl/wave_trigger.sv
// wave_trigger: positive-going zero-crossing detector, single-cycle trigger qualified by new_sample_ready
// WAVE_CAPTURE_TIMEOUT_EN adds a forced trigger after TIMEOUT_SAMPLES samples without a crossing
module wave_trigger #(
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic new_sample_ready,
    input  logic sign,
    input  logic armed,
    output logic trigger
);
    logic prev_neg;
    logic timeout;

    always_ff @(posedge clk or posedge reset)
        if (reset) prev_neg <= 1'b0;
        else if (new_sample_ready) prev_neg <= sign;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_SAMPLES + 1);
    logic [CW-1:0] cnt;
    // Counter saturates at the limit so the very next sample forces the trigger
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (!armed) cnt <= '0;
        else if (new_sample_ready && !trigger) cnt <= cnt + 1'b1;
    assign timeout = cnt == CW'(TIMEOUT_SAMPLES);
`else
    assign timeout = 1'b0;
`endif

    assign trigger = new_sample_ready & armed & ((prev_neg & ~sign) | timeout);
endmodule

// File: rtl/wave_capture.sv
// wave_capture: writes 256 offset-binary samples after a rising zero crossing into the idle bank, swaps on display idle
// WAVE_CAPTURE_TIMEOUT_EN enables a forced trigger on DC or silent input
module wave_capture #(
    parameter int SAMPLE_W = wave_pkg::SAMPLE_W,
    parameter int BANK_AW = wave_pkg::BANK_AW,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [BANK_AW:0]    write_address,
    output logic                write_enable,
    output logic [7:0]          write_sample,
    output logic                read_index
);
    import wave_pkg::*;

    state_t state, state_n;
    logic [BANK_AW-1:0] index;
    logic trigger, accept, swap;

    wave_trigger #(.TIMEOUT_SAMPLES(TIMEOUT_SAMPLES)) u_trigger (
        .clk(clk),
        .reset(reset),
        .new_sample_ready(new_sample_ready),
        .sign(new_sample_in[SAMPLE_W-1]),
        .armed(state == ARMED),
        .trigger(trigger)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ARMED;
        else state <= state_n;

    always_comb
        state_n = state == ARMED  ? (trigger ? ACTIVE : ARMED) :
                  state == ACTIVE ? ((new_sample_ready && &index) ? WAIT : ACTIVE) :
                                    (wave_display_idle ? ARMED : WAIT);

    always_comb begin
        accept = state == ARMED ? trigger : (state == ACTIVE) & new_sample_ready;
        swap = (state == WAIT) & wave_display_idle;
    end

    // Index wraps to 0 on the last write, so ARMED always starts a capture at 0
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            index <= '0;
            read_index <= 1'b0;
            write_enable <= 1'b0;
            write_address <= '0;
            write_sample <= '0;
        end else begin
            write_enable <= accept;
            if (accept) begin
                write_address <= {~read_index, index};
                write_sample <= to_offset(new_sample_in);
                index <= index + 1'b1;
            end
            if (swap) read_index <= ~read_index;
        end
endmodule
